// File: rtl/per2axi_pkg.sv
// rtl/per2axi_pkg.sv - shared helpers and types for the per2axi channel FIFOs
package per2axi_pkg;

    localparam int STATUS_CNT_W = 16;

    typedef struct packed {
        logic [STATUS_CNT_W-1:0] count;
        logic                    almost_full;
        logic [STATUS_CNT_W-1:0] peak;
    } fifo_status_t;

    // Pointer width that stays legal (>=1 bit) even for a single-entry FIFO
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/per2axi_fifo_ptr.sv
// rtl/per2axi_fifo_ptr.sv - wrap-at-DEPTH FIFO pointer with increment and clear
module per2axi_fifo_ptr
    import per2axi_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = clog2_min1(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [PTR_W-1:0] ptr_o
);

    if (DEPTH == 1) begin : g_single
        assign ptr_o = '0;
    end else begin : g_wrap
        logic [PTR_W-1:0] ptr_q;

        // Explicit compare so non power-of-2 depths wrap correctly
        always_ff @(posedge clk_i) begin
            if (rst_i || clr_i) begin
                ptr_q <= '0;
            end else if (inc_i) begin
                ptr_q <= (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
            end
        end

        assign ptr_o = ptr_q;
    end

endmodule

// File: rtl/per2axi_fifo_ft.sv
// rtl/per2axi_fifo_ft.sv - elastic FIFO with fall-through, flush and status; peak tracking under PER2AXI_FIFO_PEAK_EN
module per2axi_fifo_ft
    import per2axi_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 2,
    parameter bit FALL_THROUGH = 1'b0,
    parameter int AF_THR       = DEPTH - 1,
    localparam int CNT_W       = $clog2(DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  ready_o,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  ready_i,
    output logic [CNT_W-1:0]      count_o,
    output logic                  almost_full_o,
    output logic [CNT_W-1:0]      peak_o
);

    localparam int PTR_W = clog2_min1(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_next;
    logic                  full;
    logic                  empty;
    logic                  bypass;
    logic                  push;
    logic                  pop;
    logic                  wr_en;
    logic                  rd_en;

    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign bypass  = FALL_THROUGH && empty;
    assign ready_o = !full && !flush_i;

    always_comb begin
        valid_o = 1'b0;
        data_o  = mem[rd_ptr];
        if (bypass) begin
            valid_o = valid_i && !flush_i;
            data_o  = data_i;
        end else begin
            valid_o = !empty && !flush_i;
        end
    end

    assign push = valid_i && ready_o;
    assign pop  = valid_o && ready_i;

    // A bypass beat taken downstream in the same cycle never touches storage
    assign wr_en = push && !(bypass && ready_i);
    assign rd_en = pop && !bypass;

    always_comb begin
        cnt_next = cnt_q;
        if (wr_en && !rd_en) begin
            cnt_next = cnt_q + CNT_W'(1);
        end else if (rd_en && !wr_en) begin
            cnt_next = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_ptr] <= data_i;
        end
    end

    per2axi_fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (flush_i),
        .inc_i (wr_en),
        .ptr_o (wr_ptr)
    );

    per2axi_fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (flush_i),
        .inc_i (rd_en),
        .ptr_o (rd_ptr)
    );

    assign count_o       = cnt_q;
    assign almost_full_o = (cnt_q >= CNT_W'(AF_THR));

`ifdef PER2AXI_FIFO_PEAK_EN
    logic [CNT_W-1:0] peak_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            peak_q <= '0;
        end else if (cnt_next > peak_q) begin
            peak_q <= cnt_next;
        end
    end

    assign peak_o = peak_q;
`else
    assign peak_o = '0;
`endif

endmodule

// File: tb/tb_per2axi_fifo_ft.sv
// tb/tb_per2axi_fifo_ft.sv - directed self-checking bench for per2axi_fifo_ft
module tb_per2axi_fifo_ft;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

`ifdef PER2AXI_FIFO_PEAK_EN
    localparam logic [1:0] PEAK_AT_TWO = 2'd2;
`else
    localparam logic [1:0] PEAK_AT_TWO = 2'd0;
`endif

    // a: DEPTH=3, storage mode, AF_THR=2
    logic       flush_a = 0, valid_a = 0, ready_a = 0;
    logic [7:0] data_a = 0;
    logic       rdy_o_a, vld_o_a, af_a;
    logic [7:0] dout_a;
    logic [1:0] count_a, peak_a;

    per2axi_fifo_ft #(.DATA_WIDTH(8), .DEPTH(3), .FALL_THROUGH(1'b0), .AF_THR(2)) u_a (
        .clk_i(clk), .rst_i(rst), .flush_i(flush_a), .valid_i(valid_a), .data_i(data_a),
        .ready_o(rdy_o_a), .valid_o(vld_o_a), .data_o(dout_a), .ready_i(ready_a),
        .count_o(count_a), .almost_full_o(af_a), .peak_o(peak_a)
    );

    // b: DEPTH=2, storage mode
    logic       flush_b = 0, valid_b = 0, ready_b = 0;
    logic [7:0] data_b = 0;
    logic       rdy_o_b, vld_o_b, af_b;
    logic [7:0] dout_b;
    logic [1:0] count_b, peak_b;

    per2axi_fifo_ft #(.DATA_WIDTH(8), .DEPTH(2), .FALL_THROUGH(1'b0)) u_b (
        .clk_i(clk), .rst_i(rst), .flush_i(flush_b), .valid_i(valid_b), .data_i(data_b),
        .ready_o(rdy_o_b), .valid_o(vld_o_b), .data_o(dout_b), .ready_i(ready_b),
        .count_o(count_b), .almost_full_o(af_b), .peak_o(peak_b)
    );

    // c: DEPTH=2, fall-through
    logic       flush_c = 0, valid_c = 0, ready_c = 0;
    logic [7:0] data_c = 0;
    logic       rdy_o_c, vld_o_c, af_c;
    logic [7:0] dout_c;
    logic [1:0] count_c, peak_c;

    per2axi_fifo_ft #(.DATA_WIDTH(8), .DEPTH(2), .FALL_THROUGH(1'b1)) u_c (
        .clk_i(clk), .rst_i(rst), .flush_i(flush_c), .valid_i(valid_c), .data_i(data_c),
        .ready_o(rdy_o_c), .valid_o(vld_o_c), .data_o(dout_c), .ready_i(ready_c),
        .count_o(count_c), .almost_full_o(af_c), .peak_o(peak_c)
    );

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            checks++; if (vld_o_a !== 1'b0) begin errors++; $display("FAIL reset_valid cyc %0d got %b exp 0", i, vld_o_a); end
            checks++; if (rdy_o_a !== 1'b1) begin errors++; $display("FAIL reset_ready cyc %0d got %b exp 1", i, rdy_o_a); end
            checks++; if (count_a !== 2'd0) begin errors++; $display("FAIL reset_count cyc %0d got %0d exp 0", i, count_a); end
        end
        checks++; if (af_a !== 1'b0) begin errors++; $display("FAIL reset_af got %b exp 0", af_a); end
        checks++; if (peak_a !== 2'd0) begin errors++; $display("FAIL reset_peak got %0d exp 0", peak_a); end
    endtask

    task automatic test_fill_drain();
        logic [7:0] pat [3];
        pat[0] = 8'hA1; pat[1] = 8'hA2; pat[2] = 8'hA3;
        @(negedge clk);
        ready_a = 1'b0; valid_a = 1'b1; data_a = pat[0];
        #1;
        checks++; if (rdy_o_a !== 1'b1) begin errors++; $display("FAIL fill_ready0 got %b exp 1", rdy_o_a); end
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            checks++; if (count_a !== i[1:0]) begin errors++; $display("FAIL fill_count got %0d exp %0d", count_a, i); end
            checks++; if (af_a !== (i >= 2)) begin errors++; $display("FAIL fill_af at %0d got %b exp %b", i, af_a, (i >= 2)); end
            checks++; if (rdy_o_a !== (i != 3)) begin errors++; $display("FAIL fill_ready at %0d got %b exp %b", i, rdy_o_a, (i != 3)); end
            if (i < 3) data_a = pat[i];
            else valid_a = 1'b0;
        end
        ready_a = 1'b1;
        #1;
        checks++; if (vld_o_a !== 1'b1 || dout_a !== pat[0]) begin errors++; $display("FAIL drain_first got v=%b d=%h exp v=1 d=%h", vld_o_a, dout_a, pat[0]); end
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            #1;
            checks++; if (count_a !== 2'(3 - i)) begin errors++; $display("FAIL drain_count got %0d exp %0d", count_a, 3 - i); end
            if (i < 3) begin
                checks++; if (vld_o_a !== 1'b1 || dout_a !== pat[i]) begin errors++; $display("FAIL drain_data got v=%b d=%h exp v=1 d=%h", vld_o_a, dout_a, pat[i]); end
            end else begin
                checks++; if (vld_o_a !== 1'b0) begin errors++; $display("FAIL drain_empty_valid got %b exp 0", vld_o_a); end
            end
        end
    endtask

    task automatic test_back_to_back();
        ready_a = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            if (k >= 1) begin
                checks++; if (vld_o_a !== 1'b1 || dout_a !== 8'(8'h10 + k - 1)) begin errors++; $display("FAIL b2b_data beat %0d got v=%b d=%h exp v=1 d=%h", k - 1, vld_o_a, dout_a, 8'(8'h10 + k - 1)); end
                checks++; if (count_a !== 2'd1) begin errors++; $display("FAIL b2b_count beat %0d got %0d exp 1", k - 1, count_a); end
            end
            if (k < 10) begin valid_a = 1'b1; data_a = 8'(8'h10 + k); end
            else valid_a = 1'b0;
        end
        @(negedge clk);
        checks++; if (count_a !== 2'd0 || vld_o_a !== 1'b0) begin errors++; $display("FAIL b2b_end got c=%0d v=%b exp c=0 v=0", count_a, vld_o_a); end
        ready_a = 1'b0;
    endtask

    task automatic test_full_pop();
        @(negedge clk);
        ready_b = 1'b0; valid_b = 1'b1; data_b = 8'hB1;
        @(negedge clk);
        data_b = 8'hB2;
        @(negedge clk);
        checks++; if (count_b !== 2'd2 || rdy_o_b !== 1'b0) begin errors++; $display("FAIL full_state got c=%0d r=%b exp c=2 r=0", count_b, rdy_o_b); end
        data_b = 8'hB3; ready_b = 1'b1;
        #1;
        checks++; if (vld_o_b !== 1'b1 || dout_b !== 8'hB1) begin errors++; $display("FAIL full_pop_data got v=%b d=%h exp v=1 d=b1", vld_o_b, dout_b); end
        @(negedge clk);
        valid_b = 1'b0;
        #1;
        checks++; if (count_b !== 2'd1) begin errors++; $display("FAIL full_pop_count got %0d exp 1", count_b); end
        checks++; if (dout_b !== 8'hB2) begin errors++; $display("FAIL full_pop_next got %h exp b2", dout_b); end
        @(negedge clk);
        checks++; if (count_b !== 2'd0 || vld_o_b !== 1'b0) begin errors++; $display("FAIL full_refused got c=%0d v=%b exp c=0 v=0", count_b, vld_o_b); end
        ready_b = 1'b0;
    endtask

    task automatic test_fall_through();
        @(negedge clk);
        valid_c = 1'b1; data_c = 8'h5C; ready_c = 1'b1;
        #1;
        checks++; if (vld_o_c !== 1'b1 || dout_c !== 8'h5C) begin errors++; $display("FAIL ft_bypass got v=%b d=%h exp v=1 d=5c", vld_o_c, dout_c); end
        @(negedge clk);
        checks++; if (count_c !== 2'd0) begin errors++; $display("FAIL ft_bypass_count got %0d exp 0", count_c); end
        data_c = 8'h77; ready_c = 1'b0;
        #1;
        checks++; if (vld_o_c !== 1'b1 || dout_c !== 8'h77) begin errors++; $display("FAIL ft_stall_out got v=%b d=%h exp v=1 d=77", vld_o_c, dout_c); end
        @(negedge clk);
        checks++; if (count_c !== 2'd1) begin errors++; $display("FAIL ft_stored_count got %0d exp 1", count_c); end
        data_c = 8'h99; ready_c = 1'b1;
        #1;
        checks++; if (vld_o_c !== 1'b1 || dout_c !== 8'h77) begin errors++; $display("FAIL ft_storage_order got v=%b d=%h exp v=1 d=77", vld_o_c, dout_c); end
        @(negedge clk);
        valid_c = 1'b0;
        #1;
        checks++; if (count_c !== 2'd1 || dout_c !== 8'h99) begin errors++; $display("FAIL ft_pushpop got c=%0d d=%h exp c=1 d=99", count_c, dout_c); end
        @(negedge clk);
        checks++; if (count_c !== 2'd0 || vld_o_c !== 1'b0) begin errors++; $display("FAIL ft_drained got c=%0d v=%b exp c=0 v=0", count_c, vld_o_c); end
        ready_c = 1'b0;
    endtask

    task automatic test_flush();
        @(negedge clk);
        flush_a = 1'b1; ready_a = 1'b0;
        @(negedge clk);
        flush_a = 1'b0; valid_a = 1'b1; data_a = 8'hC1;
        @(negedge clk);
        data_a = 8'hC2;
        @(negedge clk);
        valid_a = 1'b0;
        #1;
        checks++; if (count_a !== 2'd2) begin errors++; $display("FAIL flush_pre_count got %0d exp 2", count_a); end
        checks++; if (peak_a !== PEAK_AT_TWO) begin errors++; $display("FAIL flush_pre_peak got %0d exp %0d", peak_a, PEAK_AT_TWO); end
        @(negedge clk);
        flush_a = 1'b1; valid_a = 1'b1; data_a = 8'hC3; ready_a = 1'b1;
        #1;
        checks++; if (rdy_o_a !== 1'b0 || vld_o_a !== 1'b0) begin errors++; $display("FAIL flush_hold got r=%b v=%b exp r=0 v=0", rdy_o_a, vld_o_a); end
        @(negedge clk);
        flush_a = 1'b0; valid_a = 1'b0; ready_a = 1'b0;
        #1;
        checks++; if (count_a !== 2'd0 || peak_a !== 2'd0) begin errors++; $display("FAIL flush_clear got c=%0d p=%0d exp c=0 p=0", count_a, peak_a); end
        checks++; if (vld_o_a !== 1'b0 || af_a !== 1'b0) begin errors++; $display("FAIL flush_outputs got v=%b af=%b exp v=0 af=0", vld_o_a, af_a); end
    endtask

    task automatic test_reset_midstream();
        @(negedge clk);
        ready_b = 1'b0; valid_b = 1'b1; data_b = 8'hD1;
        @(negedge clk);
        valid_b = 1'b0; rst = 1'b1;
        #1;
        checks++; if (count_b !== 2'd1) begin errors++; $display("FAIL mid_pre_count got %0d exp 1", count_b); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (count_b !== 2'd0 || vld_o_b !== 1'b0 || rdy_o_b !== 1'b1) begin errors++; $display("FAIL mid_reset got c=%0d v=%b r=%b exp c=0 v=0 r=1", count_b, vld_o_b, rdy_o_b); end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_back_to_back();
        test_full_pop();
        test_fall_through();
        test_flush();
        test_reset_midstream();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
